lsu_port_ctrl: RTL and testbench
================================

Name: lsu_port_ctrl

Overview:
- Load/store control stage directly upstream of the memory module's data port (port 1).
- Accepts one memory instruction at a time from execute and issues a single request on port 1.
- Builds the 8-byte-aligned address, byte mask and shifted store data, then waits for the port-1 response.
- Aligns and sign/zero-extends load data and hands a result, or an exception, to writeback.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; byte lanes = DATA_W/8 = 8.
- TIMEOUT, 255, max WAIT cycles before bus error; counter width = clog2(TIMEOUT+1).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a memory instruction.
- ex_ready  out  1  high only in IDLE.
- ex_is_store  in  1  1 = store, 0 = load.
- ex_op  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
- ex_addr  in  ADDR_W  byte address.
- ex_wdata  in  DATA_W  store data, LSB-justified.
- mem_req_valid  out  1  to port-1 req_valid.
- mem_req_addr  out  ADDR_W  ex_addr with bits [2:0] cleared.
- mem_req_mask  out  8  byte enables.
- mem_req_op  out  3  registered ex_op.
- mem_req_wdata  out  DATA_W  store data shifted left by addr[2:0]*8.
- mem_req_memen  out  1  equals mem_req_valid.
- mem_req_wen  out  1  mem_req_valid & store.
- mem_resp_valid  in  1  from port-1 resp_valid.
- mem_resp_rdata  in  DATA_W  from port-1 resp_rdata.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts.
- wb_data  out  DATA_W  extended load data; 0 for stores and errors.
- wb_misalign  out  1  misaligned-access exception.
- wb_buserr  out  1  response-timeout exception.

Behaviour:
- Reset: all outputs 0, state IDLE, registers 0; takes effect immediately and aborts any operation.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ex_ready=1.
  - On ex_valid, register is_store, op, addr and wdata.
  - Size = 1/2/4/8 bytes from op[1:0].
  - Misaligned when (addr & (size-1)) != 0: go to DONE with misalign=1, no memory request.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1 for exactly one cycle.
  - Mask = ((1<<size)-1) << addr[2:0].
  - If mem_resp_valid is asserted in the same cycle (zero-latency memory), capture the response and go to DONE.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - Request outputs low; the counter increments each cycle.
  - mem_resp_valid: capture rdata, go to DONE.
  - Counter reaching TIMEOUT without a response: go to DONE with buserr=1.
  - If the response and the timeout land in the same cycle, the response wins.
- DONE:
  - wb_valid=1; wb_data and flags held stable until wb_ready.
  - wb_valid & wb_ready: go to IDLE. The next ex_valid is accepted no earlier than the following cycle (max throughput one access per 3 cycles).
- Load data: shifted = rdata >> (addr[2:0]*8); low size bytes kept.
  - op[2]=0: sign-extend.
  - op[2]=1: zero-extend.
  - op 3 (D) passes through.
- mem_resp_valid outside REQ/WAIT is ignored.
- Stores return wb_data=0 after the response.
- Illegal op 7 is treated as misaligned.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants OP_B..OP_WU.
  - State enum.
  - Function size_of(op).
- Sub-module lsu_load_align (combinational): rdata, offset and op in; extended wb_data out.

Test Plan:
- LD at 0x80000010, response 2 cycles later with rdata 0x1122334455667788 -> wb_data 0x1122334455667788; mask 0xFF; memen=1, wen=0.
- LB at 0x80000003, rdata 0x00000000F2000000 -> mem_req_addr 0x80000000, mask 0x08, wb_data 0xFFFFFFFFFFFFFFF2; the LBU variant gives 0xF2.
- SH at 0x80000006, wdata 0xBEEF, response in the same cycle as req -> mask 0xC0, wdata 0xBEEF000000000000, wen=1, wb_valid the next cycle.
- LW at 0x80000002 -> no mem_req_valid, wb_misalign=1 one cycle after acceptance.
- Load with no response -> wb_buserr=1 after TIMEOUT WAIT cycles; hold wb_ready=0 for 5 cycles and confirm outputs stay stable.
- Assert reset mid-WAIT -> outputs 0 immediately, state IDLE, ex_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port controller.
//   - funct3 encodings of the memory operations
//   - controller state enum
//   - size_of(): access size in bytes from funct3
package lsu_pkg;

   localparam logic [2:0] OP_B   = 3'd0;
   localparam logic [2:0] OP_H   = 3'd1;
   localparam logic [2:0] OP_W   = 3'd2;
   localparam logic [2:0] OP_D   = 3'd3;
   localparam logic [2:0] OP_BU  = 3'd4;
   localparam logic [2:0] OP_HU  = 3'd5;
   localparam logic [2:0] OP_WU  = 3'd6;
   localparam logic [2:0] OP_ILL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // 1, 2, 4 or 8 bytes; op[2] only selects sign vs zero extension.
   function automatic logic [3:0] size_of(input logic [2:0] op);
      return 4'd1 << op[1:0];
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata  in  DATA_W  raw 8-byte word from the memory port
//   offset in  3       byte offset of the access inside the word
//   op     in  3       funct3 of the load
//   data   out DATA_W  right-justified, sign- or zero-extended result
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [2:0]        offset,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      data    = shifted;
      case (op)
         OP_B:  data = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
         OP_BU: data = {{(DATA_W-8){1'b0}},         shifted[7:0]};
         OP_H:  data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         OP_HU: data = {{(DATA_W-16){1'b0}},        shifted[15:0]};
         OP_W:  data = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
         OP_WU: data = {{(DATA_W-32){1'b0}},        shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_port_ctrl.sv
// Load/store control stage in front of memory data port 1.
// Takes one memory instruction at a time from execute, issues a single
// port-1 request, waits for the response (or a timeout) and hands the
// extended load data or an exception to writeback.
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   ex_*                      instruction from execute (ex_ready high in IDLE)
//   mem_req_*                 port-1 request, valid for exactly one cycle
//   mem_resp_valid/rdata      port-1 response
//   wb_*                      result / exception to writeback, held until wb_ready
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new instruction from execute
// REQ     | request driven on port 1 for this single cycle
// WAIT    | waiting for the response, timeout counter running
// DONE    | result or exception presented to writeback
module lsu_port_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_is_store,
   input  logic [2:0]        ex_op,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [7:0]        mem_req_mask,
   output logic [2:0]        mem_req_op,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic              mem_req_memen,
   output logic              mem_req_wen,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_misalign,
   output logic              wb_buserr
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e        state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              misalign_q, misalign_d;
   logic              buserr_q, buserr_d;

   logic [DATA_W-1:0] load_data;
   logic [2:0]        ex_lsb_mask;
   logic              ex_misaligned;
   logic              in_req;
   logic              in_done;

   lsu_load_align #(.DATA_W(DATA_W)) u_align (
      .rdata  (mem_resp_rdata),
      .offset (addr_q[2:0]),
      .op     (op_q),
      .data   (load_data)
   );

   always_comb begin
      ex_lsb_mask   = 3'(size_of(ex_op) - 4'd1);
      ex_misaligned = (ex_op == OP_ILL) || ((ex_addr[2:0] & ex_lsb_mask) != 3'd0);

      state_d    = state_q;
      is_store_d = is_store_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      wb_data_d  = wb_data_q;
      misalign_d = misalign_q;
      buserr_d   = buserr_q;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               is_store_d = ex_is_store;
               op_d       = ex_op;
               addr_d     = ex_addr;
               wdata_d    = ex_wdata;
               wb_data_d  = '0;
               buserr_d   = 1'b0;
               misalign_d = ex_misaligned;
               state_d    = ex_misaligned ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_resp_valid) begin
               wb_data_d = is_store_q ? '0 : load_data;
               state_d   = ST_DONE;
            end else begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A response arriving on the last counted cycle still wins.
            if (mem_resp_valid) begin
               wb_data_d = is_store_q ? '0 : load_data;
               state_d   = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               buserr_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         is_store_q <= 1'b0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
         buserr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
         buserr_q   <= buserr_d;
      end
   end

   assign in_req  = (state_q == ST_REQ);
   assign in_done = (state_q == ST_DONE);

   // Gated with reset so every output reads 0 while reset is held.
   assign ex_ready = (state_q == ST_IDLE) & reset;

   assign mem_req_valid = in_req;
   assign mem_req_memen = in_req;
   assign mem_req_wen   = in_req & is_store_q;
   assign mem_req_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_req_op    = in_req ? op_q : 3'd0;
   assign mem_req_mask  = in_req ? (8'((16'd1 << size_of(op_q)) - 16'd1) << addr_q[2:0]) : 8'd0;
   assign mem_req_wdata = in_req ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;

   assign wb_valid    = in_done;
   assign wb_data     = in_done ? wb_data_q : '0;
   assign wb_misalign = in_done & misalign_q;
   assign wb_buserr   = in_done & buserr_q;

endmodule

// File: tb/tb_lsu_port_ctrl.sv
module tb_lsu_port_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_is_store;
   logic [2:0]  ex_op;
   logic [31:0] ex_addr;
   logic [63:0] ex_wdata;
   logic        mem_req_valid, mem_req_memen, mem_req_wen;
   logic [31:0] mem_req_addr;
   logic [7:0]  mem_req_mask;
   logic [2:0]  mem_req_op;
   logic [63:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        wb_valid, wb_ready, wb_misalign, wb_buserr;
   logic [63:0] wb_data;

   int checks   = 0;
   int failures = 0;

   // observations recorded by run_access
   int          o_req_cnt, o_wb_cycle;
   logic [31:0] o_addr;
   logic [7:0]  o_mask;
   logic [2:0]  o_op;
   logic [63:0] o_wdata, o_wb_data;
   logic        o_wen, o_memen, o_quiet, o_mis, o_berr, o_stable;
   logic        o_ready_idle, o_ready_done, o_ready_after, o_wbv_after;

   lsu_port_ctrl #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
      .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_mask(mem_req_mask), .mem_req_op(mem_req_op),
      .mem_req_wdata(mem_req_wdata), .mem_req_memen(mem_req_memen),
      .mem_req_wen(mem_req_wen), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_data(wb_data), .wb_misalign(wb_misalign), .wb_buserr(wb_buserr)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic int model_size(input logic [2:0] op);
      return 1 << int'(op[1:0]);
   endfunction

   function automatic logic model_misalign(input logic [2:0] op, input logic [31:0] addr);
      return (op == 3'd7) || ((addr % model_size(op)) != 0);
   endfunction

   function automatic logic [7:0] model_mask(input logic [2:0] op, input logic [31:0] addr);
      logic [7:0] m;
      int off, sz;
      m = 8'd0; off = int'(addr[2:0]); sz = model_size(op);
      for (int i = 0; i < 8; i++) if (i >= off && i < off + sz) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [31:0] addr);
      logic [127:0] v;
      v = {64'd0, wd} << (8 * int'(addr[2:0]));
      return v[63:0];
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] op, input logic [31:0] addr);
      logic [127:0] v, keep;
      int sz;
      sz   = model_size(op);
      v    = {64'd0, rd} >> (8 * int'(addr[2:0]));
      keep = (128'd1 << (8 * sz)) - 128'd1;
      v    = v & keep;
      if (!op[2] && sz < 8 && v[8*sz-1]) v = v | ~keep;
      return v[63:0];
   endfunction

   // ---------------- stimulus driver (records, does not judge) ----------------
   // lat: cycle index (0 = REQ cycle) at which the response is driven; -1 = never.
   task automatic run_access(input logic st, input logic [2:0] op, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd, input int lat, input int hold);
      int c;
      @(negedge clock);
      o_ready_idle = ex_ready;
      ex_valid = 1'b1; ex_is_store = st; ex_op = op; ex_addr = addr; ex_wdata = wd;
      @(posedge clock); #1;
      ex_valid = 1'b0; ex_is_store = 1'($urandom); ex_op = 3'($urandom);
      ex_addr = $urandom; ex_wdata = {$urandom, $urandom};
      o_req_cnt = 0; o_quiet = 1'b1; o_wb_cycle = -1; o_memen = 1'b0; o_wen = 1'b0;
      o_addr = '0; o_mask = '0; o_op = '0; o_wdata = '0;
      c = 0;
      while (c < 400) begin
         if (mem_req_valid) begin
            o_req_cnt++;
            o_addr = mem_req_addr; o_mask = mem_req_mask; o_op = mem_req_op;
            o_wdata = mem_req_wdata; o_wen = mem_req_wen; o_memen = mem_req_memen;
         end else if (mem_req_memen || mem_req_wen || mem_req_mask != 0 || mem_req_addr != 0 ||
                      mem_req_wdata != 0 || mem_req_op != 0) begin
            o_quiet = 1'b0;
         end
         if (wb_valid) begin
            o_wb_cycle = c;
            break;
         end
         if (c == lat) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = rd;
         end else begin
            mem_resp_rdata = {$urandom, $urandom};
         end
         @(posedge clock); #1;
         mem_resp_valid = 1'b0;
         c++;
      end
      o_stable = 1'b1;
      o_wb_data = wb_data; o_mis = wb_misalign; o_berr = wb_buserr; o_ready_done = ex_ready;
      if (o_wb_cycle >= 0) begin
         for (int h = 0; h < hold; h++) begin
            // stray responses while in DONE must be ignored
            mem_resp_valid = 1'b1; mem_resp_rdata = {$urandom, $urandom};
            @(posedge clock); #1;
            mem_resp_valid = 1'b0;
            if (!wb_valid || wb_data !== o_wb_data || wb_misalign !== o_mis || wb_buserr !== o_berr)
               o_stable = 1'b0;
         end
         wb_ready = 1'b1;
         @(posedge clock); #1;
         wb_ready = 1'b0;
      end
      o_ready_after = ex_ready; o_wbv_after = wb_valid;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; ex_valid = 0; ex_is_store = 0; ex_op = 0; ex_addr = 0; ex_wdata = 0;
      mem_resp_valid = 0; mem_resp_rdata = 0; wb_ready = 0;
      #12;
      checks++;
      if ({ex_ready, mem_req_valid, mem_req_memen, mem_req_wen, wb_valid, wb_misalign, wb_buserr} !== 7'd0 ||
          mem_req_addr !== 0 || mem_req_mask !== 0 || mem_req_wdata !== 0 || mem_req_op !== 0 || wb_data !== 0) begin
         failures++; $display("FAIL reset_outputs got ready=%b req=%b wbv=%b exp all zero", ex_ready, mem_req_valid, wb_valid);
      end
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
         failures++; $display("FAIL reset_release_ready got ready=%b wbv=%b exp 1/0", ex_ready, wb_valid);
      end
   endtask

   task automatic test_ld();
      run_access(1'b0, 3'd3, 32'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 2, 0);
      checks++; if (o_ready_idle !== 1'b1) begin failures++; $display("FAIL ld_ready_idle got=%b exp=1", o_ready_idle); end
      checks++; if (o_req_cnt !== 1) begin failures++; $display("FAIL ld_req_count got=%0d exp=1", o_req_cnt); end
      checks++; if (o_addr !== 32'h8000_0010) begin failures++; $display("FAIL ld_addr got=%h exp=80000010", o_addr); end
      checks++; if (o_mask !== 8'hFF) begin failures++; $display("FAIL ld_mask got=%h exp=ff", o_mask); end
      checks++; if (o_memen !== 1'b1 || o_wen !== 1'b0) begin failures++; $display("FAIL ld_memen_wen got=%b%b exp=10", o_memen, o_wen); end
      checks++; if (o_wb_cycle !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", o_wb_cycle); end
      checks++; if (o_wb_data !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL ld_data got=%h exp=1122334455667788", o_wb_data); end
      checks++; if (o_quiet !== 1'b1) begin failures++; $display("FAIL ld_req_quiet got=%b exp=1", o_quiet); end
      checks++; if (o_ready_done !== 1'b0 || o_ready_after !== 1'b1 || o_wbv_after !== 1'b0) begin
         failures++; $display("FAIL ld_handshake got done_rdy=%b after_rdy=%b after_wbv=%b exp 0/1/0", o_ready_done, o_ready_after, o_wbv_after); end
   endtask

   task automatic test_lb_lbu();
      run_access(1'b0, 3'd0, 32'h8000_0003, 64'd0, 64'h0000_0000_F200_0000, 1, 1);
      checks++; if (o_addr !== 32'h8000_0000) begin failures++; $display("FAIL lb_addr got=%h exp=80000000", o_addr); end
      checks++; if (o_mask !== 8'h08) begin failures++; $display("FAIL lb_mask got=%h exp=08", o_mask); end
      checks++; if (o_wb_data !== 64'hFFFF_FFFF_FFFF_FFF2) begin failures++; $display("FAIL lb_data got=%h exp=fffffffffffffff2", o_wb_data); end
      run_access(1'b0, 3'd4, 32'h8000_0003, 64'd0, 64'h0000_0000_F200_0000, 1, 0);
      checks++; if (o_wb_data !== 64'h0000_0000_0000_00F2) begin failures++; $display("FAIL lbu_data got=%h exp=f2", o_wb_data); end
      checks++; if (o_mask !== 8'h08 || o_op !== 3'd4) begin failures++; $display("FAIL lbu_mask_op got=%h/%0d exp=08/4", o_mask, o_op); end
   endtask

   task automatic test_sh_zero_latency();
      run_access(1'b1, 3'd1, 32'h8000_0006, 64'h0000_0000_0000_BEEF, {$urandom, $urandom}, 0, 0);
      checks++; if (o_mask !== 8'hC0) begin failures++; $display("FAIL sh_mask got=%h exp=c0", o_mask); end
      checks++; if (o_wdata !== 64'hBEEF_0000_0000_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=beef000000000000", o_wdata); end
      checks++; if (o_wen !== 1'b1 || o_memen !== 1'b1) begin failures++; $display("FAIL sh_wen got=%b%b exp=11", o_wen, o_memen); end
      checks++; if (o_wb_cycle !== 1) begin failures++; $display("FAIL sh_latency got=%0d exp=1", o_wb_cycle); end
      checks++; if (o_wb_data !== 64'd0 || o_mis !== 1'b0 || o_berr !== 1'b0) begin
         failures++; $display("FAIL sh_result got=%h mis=%b berr=%b exp 0/0/0", o_wb_data, o_mis, o_berr); end
   endtask

   task automatic test_misalign();
      run_access(1'b0, 3'd2, 32'h8000_0002, 64'd0, {$urandom, $urandom}, -1, 2);
      checks++; if (o_req_cnt !== 0) begin failures++; $display("FAIL lw_mis_req got=%0d exp=0", o_req_cnt); end
      checks++; if (o_wb_cycle !== 0 || o_mis !== 1'b1 || o_berr !== 1'b0) begin
         failures++; $display("FAIL lw_mis_flag got cyc=%0d mis=%b berr=%b exp 0/1/0", o_wb_cycle, o_mis, o_berr); end
      checks++; if (o_stable !== 1'b1 || o_wb_data !== 64'd0) begin failures++; $display("FAIL lw_mis_hold got stable=%b data=%h exp 1/0", o_stable, o_wb_data); end
      run_access(1'b0, 3'd7, 32'h8000_0000, 64'd0, {$urandom, $urandom}, 0, 0);
      checks++; if (o_req_cnt !== 0 || o_mis !== 1'b1) begin failures++; $display("FAIL op7_illegal got req=%0d mis=%b exp 0/1", o_req_cnt, o_mis); end
   endtask

   task automatic test_timeout();
      logic [63:0] rd;
      run_access(1'b0, 3'd3, 32'h8000_0100, 64'd0, 64'd0, -1, 5);
      checks++; if (o_wb_cycle !== 256) begin failures++; $display("FAIL timeout_cycles got=%0d exp=256", o_wb_cycle); end
      checks++; if (o_berr !== 1'b1 || o_mis !== 1'b0 || o_wb_data !== 64'd0) begin
         failures++; $display("FAIL timeout_flags got berr=%b mis=%b data=%h exp 1/0/0", o_berr, o_mis, o_wb_data); end
      checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL timeout_hold got stable=%b exp=1", o_stable); end
      rd = {$urandom, $urandom};
      run_access(1'b0, 3'd3, 32'h8000_0108, 64'd0, rd, 255, 0);
      checks++; if (o_wb_cycle !== 256 || o_berr !== 1'b0 || o_wb_data !== rd) begin
         failures++; $display("FAIL late_resp_wins got cyc=%0d berr=%b data=%h exp 256/0/%h", o_wb_cycle, o_berr, o_wb_data, rd); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clock);
      ex_valid = 1'b1; ex_is_store = 1'b0; ex_op = 3'd3; ex_addr = 32'h8000_0200;
      @(posedge clock); #1; ex_valid = 1'b0;
      repeat (4) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({ex_ready, mem_req_valid, mem_req_memen, mem_req_wen, wb_valid, wb_misalign, wb_buserr} !== 7'd0 ||
          mem_req_addr !== 0 || mem_req_mask !== 0 || wb_data !== 0) begin
         failures++; $display("FAIL reset_mid_wait got ready=%b req=%b wbv=%b exp all zero", ex_ready, mem_req_valid, wb_valid);
      end
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (ex_ready !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_wait_idle got ready=%b req=%b wbv=%b exp 1/0/0", ex_ready, mem_req_valid, wb_valid);
      end
   endtask

   task automatic test_random();
      logic        st;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [63:0] wd, rd, exp_data;
      logic        mis;
      int          lat, errs;
      errs = 0;
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom); op = 3'($urandom_range(0, 7)); addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(model_size(op)) - 32'd1);
         wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
         lat = $urandom_range(0, 6);
         run_access(st, op, addr, wd, rd, lat, $urandom_range(0, 2));
         mis = model_misalign(op, addr);
         exp_data = (mis || st) ? 64'd0 : model_load(rd, op, addr);
         checks++;
         if (o_req_cnt !== (mis ? 0 : 1) || o_wb_cycle !== (mis ? 0 : lat + 1) || o_mis !== mis ||
             o_berr !== 1'b0 || o_wb_data !== exp_data || o_stable !== 1'b1 || o_quiet !== 1'b1 ||
             o_ready_after !== 1'b1) begin
            failures++; errs++;
            if (errs < 10) $display("FAIL rand_result n=%0d st=%b op=%0d addr=%h got data=%h cyc=%0d mis=%b req=%0d exp data=%h cyc=%0d mis=%b",
                                    n, st, op, addr, o_wb_data, o_wb_cycle, o_mis, o_req_cnt, exp_data, mis ? 0 : lat + 1, mis);
         end
         if (!mis) begin
            checks++;
            if (o_addr !== {addr[31:3], 3'b000} || o_mask !== model_mask(op, addr) || o_op !== op ||
                o_wdata !== model_wdata(wd, addr) || o_wen !== st || o_memen !== 1'b1) begin
               failures++; errs++;
               if (errs < 10) $display("FAIL rand_request n=%0d got addr=%h mask=%h wdata=%h wen=%b exp addr=%h mask=%h wdata=%h wen=%b",
                                       n, o_addr, o_mask, o_wdata, o_wen, {addr[31:3], 3'b000}, model_mask(op, addr), model_wdata(wd, addr), st);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ld();
      test_lb_lbu();
      test_sh_zero_latency();
      test_misalign();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
